quan_out_packer: RTL and testbench
==================================

Name: quan_out_packer

Overview:
- Consumer end of the requantizer output stream: accepts one uint8 `q_in` per `valid_in` cycle and packs LANES bytes into one output word.
- Upstream has no backpressure, so completed words are buffered in a small FIFO.
- Words drain to the output-buffer/DMA writer over a valid/ready handshake.
- Sits between the requantize stage and the ofmap SRAM write port.

Parameters:
- DATA_W, 8, width of one quantized element.
- LANES, 8, elements per output word; WORD_W = DATA_W*LANES (64).
- FIFO_DEPTH, 4, number of packed words buffered; power of two, >= 2.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; asynchronous, active-high.
- valid_in  input  1  `q_in` is valid this cycle; no backpressure from this block.
- q_in  input  DATA_W  requantized uint8 element.
- last_in  input  1  qualified by `valid_in`: this element ends the current row/tile; flush the partial word.
- word_out  output  WORD_W  packed word at FIFO head; element k sits in bits [k*DATA_W +: DATA_W].
- byte_mask  output  LANES  bit k = 1 when lane k of `word_out` holds real data.
- word_last  output  1  head word was closed by `last_in`.
- word_valid  output  1  FIFO not empty.
- word_ready  input  1  downstream accepts `word_out` this cycle.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words currently buffered.
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (async): lane counter 0, assembly register 0, FIFO empty, `word_valid` 0, `word_out`/`byte_mask`/`word_last` 0, `fifo_level` 0, `overflow` 0. Reset mid-word discards the partial word.
- Assembly: on `valid_in`, write `q_in` into lane `lane_cnt` of the assembly register, set that mask bit, and increment `lane_cnt`.
- Word close: a word closes when `lane_cnt` == LANES-1 or `last_in` = 1.
  - On close, push {data, mask, last} into the FIFO.
  - Clear the assembly register, mask and `lane_cnt` to 0 in the same edge.
  - Unwritten lanes of a partial word are 0 and their mask bits are 0.
- `last_in` with `lane_cnt` == LANES-1 closes a full word with `word_last` = 1 and mask all-ones.
- `last_in` without `valid_in` is ignored.
- Latency: the byte that closes a word is sampled at edge N; the word is visible with `word_valid` = 1 after edge N+1 (registered push, FIFO head read combinationally from storage).
- Handshake:
  - Pop on `word_valid` && `word_ready`.
  - `word_out`, `byte_mask` and `word_last` stay stable while `word_valid` && !`word_ready`.
  - `word_ready` while empty has no effect.
- FIFO boundaries:
  - Push and pop in the same cycle: level unchanged, legal even when full (pop frees the slot first).
  - Push when full without a pop: the word is dropped, `overflow` is set, and FIFO contents are unchanged. The assembly register still clears.
  - `overflow` is cleared only by reset.
  - Read/write pointers wrap modulo FIFO_DEPTH, with one extra bit for full/empty detection.
- `fifo_level` is updated at the same edge as the push/pop.

Optional Feature:
- Macro: QPACK_STATS_EN.
- Defined: adds two 32-bit outputs.
  - `words_pushed`: count of words accepted into the FIFO.
  - `words_dropped`: count of overflow drops.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package `qpack_pkg`: DATA_W, LANES, WORD_W constants and a packed entry typedef {data[WORD_W], mask[LANES], last}.
- One sub-module `qpack_sync_fifo`: parameterised width/depth synchronous FIFO with push, pop, full, empty and level. It is instantiated with entry width WORD_W+LANES+1.

Test Plan:
- Reset then 8 consecutive `valid_in` bytes 0x01..0x08 with `word_ready` = 1 → one word 0x0807060504030201, mask 0xFF, `word_last` 0, `word_valid` exactly 1 cycle after the 8th byte edge.
- Bytes 0xAA, 0xBB, 0xCC with `last_in` on 0xCC → word 0x0000000000CCBBAA, mask 0x07, `word_last` 1; the next byte lands in lane 0.
- `word_ready` = 0, stream 40 bytes (5 words) → `fifo_level` reaches 4, `overflow` = 1 after the 5th close; then `word_ready` = 1 drains exactly the first 4 words in order.
- FIFO full, with a word close and `word_ready` = 1 in the same cycle → no drop, `overflow` stays 0, level stays 4.
- Assert reset after 5 bytes of a word, release, send 8 bytes 0x10..0x17 → output 0x1716151413121110 only; no stale lanes.
- QPACK_STATS_EN defined, run the scenario 3 case → `words_pushed` = 4, `words_dropped` = 1.

Source files
------------

// File: rtl/qpack_pkg.sv
// rtl/qpack_pkg.sv - shared constants and FIFO entry type for the quantized output packer
package qpack_pkg;

    localparam int DATA_W  = 8;
    localparam int LANES   = 8;
    localparam int WORD_W  = DATA_W * LANES;
    localparam int LANE_W  = $clog2(LANES);
    localparam int ENTRY_W = WORD_W + LANES + 1;

    // One buffered output word: payload, per-lane valid mask, and end-of-row flag.
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [LANES-1:0]  mask;
        logic              last;
    } qpack_entry_t;

endpackage

// File: rtl/qpack_sync_fifo.sv
// rtl/qpack_sync_fifo.sv - synchronous FIFO with combinational head read and level output
module qpack_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit so equal indices can be told apart as full or empty.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the head slot first, so a push into a full FIFO is accepted alongside a pop.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/quan_out_packer.sv
// rtl/quan_out_packer.sv - packs requantized bytes into words and buffers them; QPACK_STATS_EN adds push/drop counters
module quan_out_packer
    import qpack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [DATA_W-1:0]             q_in,
    input  logic                          last_in,
    output logic [WORD_W-1:0]             word_out,
    output logic [LANES-1:0]              byte_mask,
    output logic                          word_last,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
`ifdef QPACK_STATS_EN
    ,
    output logic [31:0]                   words_pushed,
    output logic [31:0]                   words_dropped
`endif
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic              push_q, push_d;
    qpack_entry_t      push_entry_q, push_entry_d;
    logic              overflow_q, overflow_d;

    logic [WORD_W-1:0] wr_data;
    logic [LANES-1:0]  wr_mask;
    logic              close;

    logic              fifo_full;
    logic              fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    qpack_entry_t      head;
    logic              pop;
    logic              drop;

    // Merge the incoming byte into its lane; a closing byte hands the whole word to the push stage.
    always_comb begin
        lane_cnt_d   = lane_cnt_q;
        data_d       = data_q;
        mask_d       = mask_q;
        push_d       = 1'b0;
        push_entry_d = push_entry_q;
        wr_data      = data_q;
        wr_mask      = mask_q;
        close        = valid_in && ((lane_cnt_q == LAST_LANE) || last_in);
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt_q == LANE_W'(k)) begin
                wr_data[k*DATA_W +: DATA_W] = q_in;
                wr_mask[k]                  = 1'b1;
            end
        end
        if (valid_in) begin
            if (close) begin
                push_d            = 1'b1;
                push_entry_d.data = wr_data;
                push_entry_d.mask = wr_mask;
                push_entry_d.last = last_in;
                data_d            = '0;
                mask_d            = '0;
                lane_cnt_d        = '0;
            end else begin
                data_d     = wr_data;
                mask_d     = wr_mask;
                lane_cnt_d = lane_cnt_q + 1'b1;
            end
        end
    end

    // A push that finds the FIFO full with no simultaneous pop is lost and latched as overflow.
    assign pop  = !fifo_empty && word_ready;
    assign drop = push_q && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q | drop;
    end

    // Assembly, registered push stage and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_cnt_q   <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            push_q       <= push_d;
            push_entry_q <= push_entry_d;
            overflow_q   <= overflow_d;
        end
    end

    qpack_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .wdata (push_entry_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Head fields are forced to zero while nothing is buffered.
    assign head       = fifo_rdata;
    assign word_valid = !fifo_empty;
    assign word_out   = word_valid ? head.data : '0;
    assign byte_mask  = word_valid ? head.mask : '0;
    assign word_last  = word_valid ? head.last : 1'b0;
    assign overflow   = overflow_q;

`ifdef QPACK_STATS_EN
    logic [31:0] words_pushed_q, words_pushed_d;
    logic [31:0] words_dropped_q, words_dropped_d;

    // Accepted pushes and drops are counted separately; both wrap naturally.
    always_comb begin
        words_pushed_d  = words_pushed_q;
        words_dropped_d = words_dropped_q;
        if (push_q && !drop) begin
            words_pushed_d = words_pushed_q + 32'd1;
        end
        if (drop) begin
            words_dropped_d = words_dropped_q + 32'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_pushed_q  <= '0;
            words_dropped_q <= '0;
        end else begin
            words_pushed_q  <= words_pushed_d;
            words_dropped_q <= words_dropped_d;
        end
    end

    assign words_pushed  = words_pushed_q;
    assign words_dropped = words_dropped_q;
`endif

endmodule

// File: tb/tb_quan_out_packer.sv
// tb/tb_quan_out_packer.sv - self-checking bench for quan_out_packer
module tb_quan_out_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [7:0]  q_in;
    logic        last_in;
    logic [63:0] word_out;
    logic [7:0]  byte_mask;
    logic        word_last;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
`ifdef QPACK_STATS_EN
    logic [31:0] words_pushed;
    logic [31:0] words_dropped;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    quan_out_packer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .q_in       (q_in),
        .last_in    (last_in),
        .word_out   (word_out),
        .byte_mask  (byte_mask),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef QPACK_STATS_EN
        ,
        .words_pushed  (words_pushed),
        .words_dropped (words_dropped)
`endif
    );

    typedef struct {
        logic        v;
        logic [7:0]  q;
        logic        l;
        logic        r;
        logic        ev;
        logic [63:0] ew;
        logic [7:0]  em;
        logic        el;
        logic [2:0]  elev;
        logic        eo;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic v, input logic [7:0] q, input logic l, input logic r,
                                input logic ev, input logic [63:0] ew, input logic [7:0] em,
                                input logic el, input logic [2:0] elev, input logic eo);
        vec_t t;
        t.v = v; t.q = q; t.l = l; t.r = r;
        t.ev = ev; t.ew = ew; t.em = em; t.el = el; t.elev = elev; t.eo = eo;
        return t;
    endfunction

    function automatic logic [63:0] word_of(input int k);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) begin
            w[j*8 +: 8] = 8'(8*k + j);
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] q, input logic l, input logic r);
        valid_in   = v;
        q_in       = q;
        last_in    = l;
        word_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        valid_in   = 1'b0;
        q_in       = '0;
        last_in    = 1'b0;
        word_ready = 1'b0;
        reset      = 1'b1;
        #12;
        reset      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Basic packing and partial-word flush table.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = mk(1'b1, 8'(i + 1), 1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 3'd0, 1'b0);
        end
        tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 64'h0807060504030201, 8'hFF, 1'b0, 3'd1, 1'b0);
        tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 3'd0, 1'b0);
        tbl[10] = mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 3'd0, 1'b0);
        tbl[11] = mk(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 3'd0, 1'b0);
        tbl[12] = mk(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 3'd0, 1'b0);
        tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 64'h0000000000CCBBAA, 8'h07, 1'b1, 3'd1, 1'b0);
        tbl[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 3'd0, 1'b0);
        tbl[15] = mk(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 3'd0, 1'b0);
        tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 64'h0000000000000055, 8'h01, 1'b1, 3'd1, 1'b0);
        tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 3'd0, 1'b0);

        // Reset state, sampled while reset is held.
        valid_in = 1'b0; q_in = '0; last_in = 1'b0; word_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_word_out",   word_out,   64'h0);
        chk("rst_byte_mask",  byte_mask,  64'h0);
        chk("rst_word_last",  word_last,  64'h0);
        chk("rst_word_valid", word_valid, 64'h0);
        chk("rst_fifo_level", fifo_level, 64'h0);
        chk("rst_overflow",   overflow,   64'h0);
`ifdef QPACK_STATS_EN
        chk("rst_words_pushed",  words_pushed,  64'h0);
        chk("rst_words_dropped", words_dropped, 64'h0);
`endif
        #11;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].v, tbl[i].q, tbl[i].l, tbl[i].r);
            chk($sformatf("v%0d_word_valid", i), word_valid, tbl[i].ev);
            chk($sformatf("v%0d_fifo_level", i), fifo_level, tbl[i].elev);
            chk($sformatf("v%0d_overflow", i),   overflow,   tbl[i].eo);
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_word_out", i),  word_out,  tbl[i].ew);
                chk($sformatf("v%0d_byte_mask", i), byte_mask, tbl[i].em);
                chk($sformatf("v%0d_word_last", i), word_last, tbl[i].el);
            end
        end

        // Overflow: five words with the sink stalled, then drain.
        apply_reset();
        for (int b = 0; b < 40; b++) begin
            cyc(1'b1, 8'(b), 1'b0, 1'b0);
            if (b == 32) begin
                chk("ovf_level_at_4", fifo_level, 64'd4);
                chk("ovf_not_yet",    overflow,   64'd0);
            end
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_level_full", fifo_level, 64'd4);
        chk("ovf_set",        overflow,   64'd1);
        chk("ovf_head_held",  word_out,   word_of(0));
`ifdef QPACK_STATS_EN
        chk("stats_pushed",  words_pushed,  64'd4);
        chk("stats_dropped", words_dropped, 64'd1);
`endif
        for (int k = 0; k < 4; k++) begin
            word_ready = 1'b1;
            #1;
            chk($sformatf("drain%0d_valid", k), word_valid, 64'd1);
            chk($sformatf("drain%0d_word", k),  word_out,   word_of(k));
            chk($sformatf("drain%0d_mask", k),  byte_mask,  64'hFF);
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("drain_empty",    word_valid, 64'd0);
        chk("drain_level",    fifo_level, 64'd0);
        chk("ovf_sticky",     overflow,   64'd1);

        // Full FIFO with a push and pop landing on the same edge.
        apply_reset();
        for (int b = 0; b < 32; b++) begin
            cyc(1'b1, 8'(b), 1'b0, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pp_level_full", fifo_level, 64'd4);
        for (int b = 32; b < 40; b++) begin
            cyc(1'b1, 8'(b), 1'b0, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("pp_level_kept", fifo_level, 64'd4);
        chk("pp_no_ovf",     overflow,   64'd0);
        chk("pp_head",       word_out,   word_of(1));

        // Reset in the middle of a word discards the partial lanes.
        apply_reset();
        for (int b = 0; b < 5; b++) begin
            cyc(1'b1, 8'(8'h30 + b), 1'b0, 1'b1);
        end
        apply_reset();
        chk("mid_rst_valid", word_valid, 64'd0);
        chk("mid_rst_level", fifo_level, 64'd0);
        for (int b = 0; b < 8; b++) begin
            cyc(1'b1, 8'(8'h10 + b), 1'b0, 1'b1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("mid_rst_word_valid", word_valid, 64'd1);
        chk("mid_rst_word",       word_out,   64'h1716151413121110);
        chk("mid_rst_mask",       byte_mask,  64'hFF);
        chk("mid_rst_last",       word_last,  64'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("mid_rst_only_one",   word_valid, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
